// File: rtl/sfp_pkg.sv
// Shared types and sizing for the SFP partial-sum exchange sequencer.
// Also used by the top-level core controller.
package sfp_pkg;

  localparam int ROWS_MAX = 16;
  localparam int RW       = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC   = 3'd1,
    DRAIN = 3'd2,
    SYNC  = 3'd3,
    DIV   = 3'd4,
    FLUSH = 3'd5
  } sfp_state_e;

  // Row counts above the FIFO depth saturate at the depth.
  function automatic logic [RW-1:0] clamp_rows(input logic [RW-1:0] n);
    return (n > RW'(ROWS_MAX)) ? RW'(ROWS_MAX) : n;
  endfunction

endpackage

// File: rtl/sfp_sync_to_cnt.sv
// Sync-wait timeout counter: counts consecutive enabled cycles and flags the
// TO_CYC-th one. Used by sfp_div_ctrl only when SFP_DIV_TIMEOUT_EN is defined.
module sfp_sync_to_cnt #(
  parameter int TO_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic hit
);

  localparam int CW = $clog2(TO_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign hit = en && (cnt_q == CW'(TO_CYC - 1));

endmodule

// File: rtl/sfp_div_ctrl.sv
// Sequencer for the partial-sum exchange between two SFP cores (acc/div/fifo_ext_rd).
// Optional sync-wait timeout is enabled by defining SFP_DIV_TIMEOUT_EN.
module sfp_div_ctrl
  import sfp_pkg::*;
#(
  parameter int TO_CYC = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [RW-1:0] num_rows,
  input  logic          out_stall,
  input  logic          peer_rdy,
  output logic          local_rdy,
  output logic          acc,
  output logic          div,
  output logic          fifo_ext_rd,
  output logic          out_valid,
  output logic [RW-1:0] out_row,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output sfp_state_e    dbg_state
);

  // Handshake: local_rdy means "sums queued and sfp_out can be accepted".
  // A row divides only when both cores are ready in the same cycle (adv), so
  // both instances see identical adv and stay in lockstep.
  sfp_state_e    state_q, state_d;
  logic [RW-1:0] n_q, n_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] dcnt_q, dcnt_d;
  logic          ext_rd_q, ov_q, done_q;
  logic [RW-1:0] out_row_q;
  logic          adv;
  logic          to_hit;
  logic [RW-1:0] start_n;

  assign start_n   = clamp_rows(num_rows);
  assign local_rdy = ((state_q == SYNC) || (state_q == DIV)) && !out_stall;
  assign adv       = local_rdy && peer_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      row_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      row_q   <= row_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    row_d   = row_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d    = start_n;
          row_d  = '0;
          dcnt_d = '0;
          if (start_n != '0) state_d = ACC;
        end
      end
      ACC: begin
        row_d = row_q + RW'(1);
        if (row_q == n_q - RW'(1)) state_d = DRAIN;
      end
      DRAIN: state_d = SYNC;
      SYNC: begin
        // The first adv only aligns both cores; no division happens here.
        if (adv)         state_d = DIV;
        else if (to_hit) state_d = IDLE;
      end
      DIV: begin
        if (adv) begin
          dcnt_d = dcnt_q + RW'(1);
          if (dcnt_q == n_q - RW'(1)) state_d = FLUSH;
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc  = (state_q == ACC);
    div  = (state_q == DIV) && adv;
    busy = (state_q != IDLE);
  end

  // sfp_row pops its ext FIFO and presents sfp_out one cycle after div.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_rd_q  <= 1'b0;
      ov_q      <= 1'b0;
      out_row_q <= '0;
      done_q    <= 1'b0;
    end else begin
      ext_rd_q  <= div;
      ov_q      <= div;
      out_row_q <= dcnt_q;
      done_q    <= ((state_q == IDLE) && start && (start_n == '0)) || (state_q == FLUSH);
    end
  end

  assign fifo_ext_rd = ext_rd_q;
  assign out_valid   = ov_q;
  assign out_row     = out_row_q;
  assign done        = done_q;
  assign dbg_state   = state_q;

`ifdef SFP_DIV_TIMEOUT_EN
  logic timeout_q;
  logic sync_wait;

  assign sync_wait = (state_q == SYNC) && !adv;

  sfp_sync_to_cnt #(.TO_CYC(TO_CYC)) u_to_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (sync_wait),
    .hit   (to_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       timeout_q <= 1'b0;
    else if (to_hit) timeout_q <= 1'b1;
  end

  assign timeout = timeout_q;
`else
  logic unused_to;
  assign unused_to = (TO_CYC != 0);
  assign to_hit    = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule
